// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP pattern and PC stride.
package instruction_fetch_pkg;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 32'd4;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter: redirect with word alignment, sequential increment and misalign flag.
module instruction_fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic            jump_misalign
);

  // A redirect always wins over the sequential step; increment wraps modulo 2^XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      jump_misalign <= 1'b0;
    end else begin
      jump_misalign <= jump_en && (jump_addr[1:0] != 2'b00);
      if (jump_en) begin
        pc <= {jump_addr[XLEN-1:2], 2'b00};
      end else if (advance) begin
        pc <= pc + XLEN'(PC_STEP);
      end else begin
        pc <= pc;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word reads over a req/ack handshake and hands results to decode,
// dropping any response made stale by a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            inst_valid,
  output logic            busy,
  output logic            jump_misalign
);

  fetch_state_e    state_r;
  logic            kill_r;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] pc_plus_s;
  logic            advance_s;

  assign pc_plus_s = pc_s + XLEN'(PC_STEP);
  assign advance_s = (state_r == FETCH_WAIT) && imem_ack && !kill_r && !jump_en;
  assign busy      = (state_r == FETCH_WAIT);

  instruction_fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .advance       (advance_s),
    .pc            (pc_s),
    .jump_misalign (jump_misalign)
  );

  // Fetch FSM with registered handshake and decode-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH_IDLE;
      kill_r     <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_VECTOR;
      inst       <= INST_NOP;
      curr_pc_fd <= RESET_VECTOR;
      next_pc_fd <= RESET_VECTOR + XLEN'(PC_STEP);
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      case (state_r)
        FETCH_IDLE: begin
          if (fetch_en && !jump_en) begin
            state_r   <= FETCH_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc_s;
          end else begin
            state_r <= FETCH_IDLE;
          end
        end
        FETCH_WAIT: begin
          if (imem_ack) begin
            state_r  <= FETCH_IDLE;
            imem_req <= 1'b0;
            kill_r   <= 1'b0;
            // A pending or coincident redirect makes this response stale.
            if (!kill_r && !jump_en) begin
              inst       <= imem_rdata;
              curr_pc_fd <= pc_s;
              next_pc_fd <= pc_plus_s;
              inst_valid <= 1'b1;
            end else begin
              inst_valid <= 1'b0;
            end
          end else if (jump_en) begin
            kill_r <= 1'b1;
          end else begin
            kill_r <= kill_r;
          end
        end
        default: begin
          state_r  <= FETCH_IDLE;
          imem_req <= 1'b0;
          kill_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; inputs driven and outputs sampled on negedge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, fetch_en, jump_en, imem_ack;
  logic [31:0] jump_addr, imem_rdata;
  logic        imem_req, inst_valid, busy, jump_misalign;
  logic [31:0] imem_addr, inst, curr_pc_fd, next_pc_fd;
  int          vectors = 0;
  int          miscompares = 0;
  int          valid_cnt = 0;

  instruction_fetch #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .jump_en(jump_en), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .inst_valid(inst_valid),
    .busy(busy), .jump_misalign(jump_misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (inst_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (inst !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0000_0013); end
    vectors++; if (curr_pc_fd !== 32'h0) begin miscompares++; $display("FAIL reset_curr: got %h want %h", curr_pc_fd, 32'h0); end
    vectors++; if (next_pc_fd !== 32'h4) begin miscompares++; $display("FAIL reset_next: got %h want %h", next_pc_fd, 32'h4); end
    vectors++; if ({imem_req, inst_valid, jump_misalign, busy} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {imem_req, inst_valid, jump_misalign, busy}); end
  endtask

  task automatic test_single_fetch();
    int v0;
    apply_reset();
    v0 = valid_cnt;
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if ({imem_req, busy} !== 2'b11) begin miscompares++; $display("FAIL single_req: got %b want 11", {imem_req, busy}); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL single_addr: got %h want %h", imem_addr, 32'h0); end
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL single_req_hold: got %b want 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    @(negedge clk); imem_ack = 1'b0;
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 32'h0050_0093) begin miscompares++; $display("FAIL single_inst: got %h want %h", inst, 32'h0050_0093); end
    vectors++; if ({curr_pc_fd, next_pc_fd} !== {32'h0, 32'h4}) begin miscompares++; $display("FAIL single_pcs: got %h/%h want 0/4", curr_pc_fd, next_pc_fd); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL single_req_drop: got %b want 0", imem_req); end
    @(negedge clk); @(negedge clk);
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL single_pulses: got %0d want 1", valid_cnt - v0); end
    vectors++; if (inst !== 32'h0050_0093) begin miscompares++; $display("FAIL single_hold: got %h want %h", inst, 32'h0050_0093); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i) * 32'd4;
      fetch_en = 1'b1;
      @(negedge clk);
      vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL b2b_addr%0d: got %h want %h", i, imem_addr, exp_pc); end
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk); imem_ack = 1'b0; fetch_en = 1'b0;
      vectors++; if (curr_pc_fd !== exp_pc || inst_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_curr%0d: got %h/%b want %h/1", i, curr_pc_fd, inst_valid, exp_pc); end
      vectors++; if (inst !== 32'hA000_0000 + 32'(i)) begin miscompares++; $display("FAIL b2b_inst%0d: got %h want %h", i, inst, 32'hA000_0000 + 32'(i)); end
      vectors++; if ({busy, imem_req} !== 2'b00) begin miscompares++; $display("FAIL b2b_noqueue%0d: got %b want 00", i, {busy, imem_req}); end
    end
  endtask

  task automatic test_jump_in_wait();
    int v0;
    apply_reset();
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0; jump_en = 1'b1; jump_addr = 32'h100;
    @(negedge clk); jump_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    v0 = valid_cnt;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL jwait_novalid: got %0d pulses want 0", valid_cnt - v0); end
    vectors++; if ({busy, inst} !== {1'b0, 32'h0000_0013}) begin miscompares++; $display("FAIL jwait_drop: got %b/%h want 0/00000013", busy, inst); end
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL jwait_addr: got %h want %h", imem_addr, 32'h100); end
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    @(negedge clk); imem_ack = 1'b0;
    vectors++; if ({curr_pc_fd, next_pc_fd} !== {32'h100, 32'h104}) begin miscompares++; $display("FAIL jwait_pcs: got %h/%h want 100/104", curr_pc_fd, next_pc_fd); end
  endtask

  task automatic test_jump_with_ack();
    apply_reset();
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; jump_en = 1'b1; jump_addr = 32'h200;
    @(negedge clk); imem_ack = 1'b0; jump_en = 1'b0;
    vectors++; if ({inst_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL jack_drop: got %b want 00", {inst_valid, busy}); end
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL jack_addr: got %h want %h", imem_addr, 32'h200); end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    apply_reset();
    jump_en = 1'b1; jump_addr = 32'h103; fetch_en = 1'b1;
    @(negedge clk); jump_en = 1'b0; fetch_en = 1'b0;
    vectors++; if ({jump_misalign, busy} !== 2'b10) begin miscompares++; $display("FAIL mis_pulse: got %b want 10", {jump_misalign, busy}); end
    @(negedge clk);
    vectors++; if (jump_misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", jump_misalign); end
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL mis_addr: got %h want %h", imem_addr, 32'h100); end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int v0;
    apply_reset();
    jump_en = 1'b1; jump_addr = 32'h40;
    @(negedge clk); jump_en = 1'b0; fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    v0 = valid_cnt;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL rstw_novalid: got %0d pulses want 0", valid_cnt - v0); end
    vectors++; if ({inst, curr_pc_fd} !== {32'h0000_0013, 32'h0}) begin miscompares++; $display("FAIL rstw_outs: got %h/%h want 00000013/0", inst, curr_pc_fd); end
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rstw_pc: got %h want %h", imem_addr, 32'h0); end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    @(negedge clk); jump_en = 1'b0; fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    @(negedge clk); imem_ack = 1'b0;
    vectors++; if ({curr_pc_fd, next_pc_fd} !== {32'hFFFF_FFFC, 32'h0}) begin miscompares++; $display("FAIL wrap_pcs: got %h/%h want fffffffc/0", curr_pc_fd, next_pc_fd); end
    fetch_en = 1'b1;
    @(negedge clk); fetch_en = 1'b0;
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %h want %h", imem_addr, 32'h0); end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_jump_in_wait();
    test_jump_with_ack();
    test_misalign();
    test_reset_in_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Producer end of the fetch-to-decode interface. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Presents the fetched word with its curr/next PC to instruction_decode on inst, curr_pc_fd and next_pc_fd. Accepts PC redirects from the execute/jump path and discards any in-flight fetch that a redirect makes stale.

Parameters:
XLEN, 32, data/address width (matches core_general.vh)
RESET_VECTOR, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  CPU clock
rst  in  1  synchronous reset, active-high
fetch_en  in  1  phase enable from core control; starts one fetch
jump_en  in  1  PC redirect request, one-cycle pulse
jump_addr  in  XLEN  redirect target
imem_req  out  1  memory request, held until ack
imem_addr  out  XLEN  word address, stable while imem_req=1
imem_ack  in  1  memory response valid, one-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
inst  out  32  fetched instruction to decode
curr_pc_fd  out  XLEN  PC of inst
next_pc_fd  out  XLEN  curr_pc_fd+4
inst_valid  out  1  one-cycle pulse when inst/curr/next update
busy  out  1  high in state WAIT
jump_misalign  out  1  one-cycle pulse when jump_en has jump_addr[1:0]!=0

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - pc=RESET_VECTOR, state=IDLE, kill=0
  - inst=32'h0000_0013 (NOP)
  - curr_pc_fd=RESET_VECTOR, next_pc_fd=RESET_VECTOR+4
  - imem_req=0, inst_valid=0, jump_misalign=0
- Reset overrides every other input in the same cycle.
- A reset while in WAIT returns the block to IDLE immediately; a late imem_ack arriving after reset is ignored.
- FSM states: IDLE, WAIT.
  - IDLE & fetch_en & !jump_en -> WAIT. Registered imem_req=1, imem_addr=pc from the next cycle.
  - IDLE & jump_en: pc<=jump_addr aligned, stay IDLE, fetch_en ignored this cycle.
  - WAIT & !imem_ack: hold imem_req and imem_addr unchanged. A jump_en here sets pc<=target and kill<=1.
  - WAIT & imem_ack & !kill & !jump_en:
    - inst<=imem_rdata, curr_pc_fd<=pc, next_pc_fd<=pc+4
    - pc<=pc+4, inst_valid=1 next cycle
    - imem_req<=0, go to IDLE
  - WAIT & imem_ack & (kill | jump_en): data discarded, no inst_valid, pc<=target if jump_en, kill<=0, imem_req<=0, go to IDLE.
- Latency: fetch_en sampled at edge N; imem_req visible at N+1. If ack arrives in cycle N+1+k, inst_valid is high in cycle N+2+k. Minimum 2 cycles.
- Outputs inst, curr_pc_fd and next_pc_fd hold their values between inst_valid pulses.
- fetch_en in WAIT is ignored, with no queuing.
- Alignment: redirect target uses {jump_addr[XLEN-1:2],2'b00}. jump_misalign pulses the following cycle.
- Arithmetic: PC+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- imem_ack while in IDLE is ignored.

Decomposition:
- core_general.vh gains:
  - FETCH_IDLE / FETCH_WAIT state encodings (1 bit)
  - INST_NOP=32'h0000_0013
  - PC_STEP=4
- Sub-module pc_reg: holds pc and handles redirect, align, increment, and misalign flag.
- The FSM and output registers stay in instruction_fetch.

Test Plan:
- Reset, then fetch_en pulse; ack 2 cycles later with rdata=32'h00500093 -> imem_addr=0; inst=32'h00500093, curr=0, next=4, one inst_valid pulse.
- Three back-to-back fetches with ack latency 0 -> addresses 0, 4, 8; curr_pc_fd 0, 4, 8; fetch_en during WAIT has no effect.
- jump_en with jump_addr=32'h100 while in WAIT, ack next cycle -> no inst_valid; next fetch has imem_addr=32'h100.
- jump_en coincident with imem_ack, jump_addr=32'h200 -> data dropped; next imem_addr=32'h200.
- jump_addr=32'h103 -> jump_misalign pulses; next imem_addr=32'h100.
- rst asserted mid-WAIT, ack arrives after rst release -> inst stays 32'h0000_0013, no inst_valid, pc=RESET_VECTOR; pc=32'hFFFF_FFFC fetch -> next_pc_fd=0.
